// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the UART command parser: FSM states, frame
// constants and abort cause codes.
package uart_cmd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_LEN,
        ST_DATA,
        ST_CSUM,
        ST_COMMIT
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE   = 2'd0,
        ERR_CSUM   = 2'd1,
        ERR_CMDLEN = 2'd2,
        ERR_LINE   = 2'd3
    } err_code_t;

    localparam logic [7:0] SYNC_BYTE = 8'h55;
    localparam logic [7:0] CMD_WRITE = 8'h01;
    localparam logic [7:0] CMD_PING  = 8'h02;

    // True for the command codes the parser knows how to execute
    function automatic logic cmd_known(input logic [7:0] cmd);
        return (cmd == CMD_WRITE) || (cmd == CMD_PING);
    endfunction

endpackage

// File: rtl/uart_cmd_parser_cmd_buf.sv
// Payload store: DEPTH x 8 bits, one synchronous write port and one
// asynchronous read port. Contents are not reset.
module cmd_buf
    import uart_cmd_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem [DEPTH];

    // Capture payload bytes as they arrive
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_cmd_parser.sv
// UART command frame parser: SYNC CMD ADDR LEN payload CSUM. Valid write
// frames are replayed as a stream of single-byte writes with a
// ready/enable handshake; malformed frames are aborted and counted.
module uart_cmd_parser
    import uart_cmd_pkg::*;
#(
    parameter int CLKS_PER_BYTE = 250,
    parameter int TIMEOUT_CLKS  = 4 * CLKS_PER_BYTE,
    parameter int MAX_LEN       = 16
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       rx_error,
    output logic       wr_en,
    input  logic       wr_ready,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       frame_ok,
    output logic       frame_err,
    output logic [1:0] err_code,
    output logic [7:0] err_cnt,
    output logic       rx_drop
);

    localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int TW = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CLKS - 1);
    localparam logic [7:0]    MAX_LEN_B  = 8'(MAX_LEN);

    state_t          state;
    err_code_t       err_code_q;
    logic [7:0]      cmd_q;
    logic [7:0]      addr_q;
    logic [7:0]      len_q;
    logic [7:0]      csum_q;
    logic [7:0]      idx;
    logic [7:0]      next_idx;
    logic [TW-1:0]   timer;
    logic            in_frame;
    logic            abort_req;
    err_code_t       abort_code;

    logic            buf_we;
    logic [AW-1:0]   buf_waddr;
    logic [AW-1:0]   buf_raddr;
    logic [7:0]      buf_rdata;

    assign err_code = err_code_q;

    cmd_buf #(
        .DEPTH (MAX_LEN),
        .AW    (AW)
    ) u_buf (
        .clk   (clk),
        .we    (buf_we),
        .waddr (buf_waddr),
        .wdata (rx_data),
        .raddr (buf_raddr),
        .rdata (buf_rdata)
    );

    // Buffer addressing: during COMMIT the read port looks one entry ahead
    // so the next write can be loaded on the same edge that accepts the
    // current one; otherwise it points at entry 0 for the first write.
    always_comb begin
        in_frame  = (state != ST_IDLE) && (state != ST_COMMIT);
        next_idx  = idx + 8'd1;
        buf_we    = (state == ST_DATA) && rx_valid && !rx_error;
        buf_waddr = idx[AW-1:0];
        buf_raddr = '0;
        if ((state == ST_COMMIT) && (next_idx < MAX_LEN_B)) begin
            buf_raddr = next_idx[AW-1:0];
        end
    end

    // Abort detection; rx_error outranks a simultaneous byte, and a byte
    // arriving on the timeout cycle keeps the frame alive.
    always_comb begin
        abort_req  = 1'b0;
        abort_code = ERR_NONE;
        if (in_frame) begin
            if (rx_error) begin
                abort_req  = 1'b1;
                abort_code = ERR_LINE;
            end else if (rx_valid) begin
                if ((state == ST_LEN) &&
                    ((rx_data > MAX_LEN_B) || !cmd_known(cmd_q))) begin
                    abort_req  = 1'b1;
                    abort_code = ERR_CMDLEN;
                end else if ((state == ST_CSUM) && (rx_data != csum_q)) begin
                    abort_req  = 1'b1;
                    abort_code = ERR_CSUM;
                end
            end else if (timer == TIMER_LAST) begin
                abort_req  = 1'b1;
                abort_code = ERR_LINE;
            end
        end
    end

    // Frame FSM with registered outputs and single-cycle status pulses
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= ST_IDLE;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            frame_ok   <= 1'b0;
            frame_err  <= 1'b0;
            rx_drop    <= 1'b0;
            err_code_q <= ERR_NONE;
            err_cnt    <= '0;
            idx        <= '0;
            timer      <= '0;
            cmd_q      <= '0;
            addr_q     <= '0;
            len_q      <= '0;
            csum_q     <= '0;
        end else begin
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            rx_drop   <= 1'b0;
            if (abort_req) begin
                state      <= ST_IDLE;
                frame_err  <= 1'b1;
                err_code_q <= abort_code;
                if (err_cnt != 8'hFF) begin
                    err_cnt <= err_cnt + 8'd1;
                end
                idx   <= '0;
                timer <= '0;
            end else begin
                if (in_frame && !rx_valid) begin
                    timer <= timer + 1'b1;
                end else begin
                    timer <= '0;
                end
                case (state)
                    ST_IDLE: begin
                        if (rx_valid && !rx_error && (rx_data == SYNC_BYTE)) begin
                            state <= ST_CMD;
                        end
                    end
                    ST_CMD: begin
                        if (rx_valid) begin
                            cmd_q  <= rx_data;
                            csum_q <= rx_data;
                            state  <= ST_ADDR;
                        end
                    end
                    ST_ADDR: begin
                        if (rx_valid) begin
                            addr_q <= rx_data;
                            csum_q <= csum_q ^ rx_data;
                            state  <= ST_LEN;
                        end
                    end
                    ST_LEN: begin
                        if (rx_valid) begin
                            len_q  <= rx_data;
                            csum_q <= csum_q ^ rx_data;
                            idx    <= '0;
                            state  <= (rx_data == '0) ? ST_CSUM : ST_DATA;
                        end
                    end
                    ST_DATA: begin
                        if (rx_valid) begin
                            csum_q <= csum_q ^ rx_data;
                            idx    <= next_idx;
                            if (next_idx == len_q) begin
                                state <= ST_CSUM;
                            end
                        end
                    end
                    ST_CSUM: begin
                        if (rx_valid) begin
                            if ((cmd_q == CMD_PING) || (len_q == '0)) begin
                                frame_ok <= 1'b1;
                                state    <= ST_IDLE;
                            end else begin
                                state   <= ST_COMMIT;
                                idx     <= '0;
                                wr_en   <= 1'b1;
                                wr_addr <= addr_q;
                                wr_data <= buf_rdata;
                            end
                        end
                    end
                    ST_COMMIT: begin
                        rx_drop <= rx_valid;
                        if (wr_en && wr_ready) begin
                            if (next_idx == len_q) begin
                                wr_en    <= 1'b0;
                                frame_ok <= 1'b1;
                                idx      <= '0;
                                state    <= ST_IDLE;
                            end else begin
                                idx     <= next_idx;
                                wr_addr <= addr_q + next_idx;
                                wr_data <= buf_rdata;
                            end
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Self-checking bench for uart_cmd_parser: a negedge monitor pops expected
// writes from a scoreboard queue; scenario tasks check pulses and status.
module tb_uart_cmd_parser;

    localparam int TIMEOUT = 1000;
    localparam int MAXLEN  = 16;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic [7:0] rx_data = '0;
    logic       rx_valid = 1'b0;
    logic       rx_error = 1'b0;
    logic       wr_en;
    logic       wr_ready = 1'b1;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       frame_ok;
    logic       frame_err;
    logic [1:0] err_code;
    logic [7:0] err_cnt;
    logic       rx_drop;

    int checks = 0;
    int errors = 0;
    int ok_seen = 0;
    int ferr_seen = 0;
    int drop_seen = 0;
    int wr_seen = 0;
    int exp_err_cnt = 0;
    logic [15:0] exp_q[$];
    logic [7:0]  pl[MAXLEN];

    always #5 clk = ~clk;

    uart_cmd_parser #(
        .CLKS_PER_BYTE (250),
        .TIMEOUT_CLKS  (TIMEOUT),
        .MAX_LEN       (MAXLEN)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_error  (rx_error),
        .wr_en     (wr_en),
        .wr_ready  (wr_ready),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .frame_ok  (frame_ok),
        .frame_err (frame_err),
        .err_code  (err_code),
        .err_cnt   (err_cnt),
        .rx_drop   (rx_drop)
    );

    // Negedge observer: scoreboard writes, stall stability, pulse counting
    task automatic monitor();
        logic       stall_prev = 1'b0;
        logic [7:0] pa = '0;
        logic [7:0] pd = '0;
        logic [15:0] e;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                stall_prev = 1'b0;
            end else begin
                if (stall_prev) begin
                    checks++;
                    if (wr_en !== 1'b1 || wr_addr !== pa || wr_data !== pd) begin
                        errors++;
                        $display("FAIL stall_stable: wr_en=%b addr=%h data=%h required 1 %h %h",
                                 wr_en, wr_addr, wr_data, pa, pd);
                    end
                end
                if (wr_en && wr_ready) begin
                    wr_seen++;
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_write: addr=%h data=%h required none", wr_addr, wr_data);
                    end else begin
                        e = exp_q.pop_front();
                        if ({wr_addr, wr_data} !== e) begin
                            errors++;
                            $display("FAIL write: addr=%h data=%h required addr=%h data=%h",
                                     wr_addr, wr_data, e[15:8], e[7:0]);
                        end
                    end
                end
                if (frame_ok)  ok_seen++;
                if (frame_err) ferr_seen++;
                if (rx_drop)   drop_seen++;
                stall_prev = wr_en && !wr_ready;
                pa = wr_addr;
                pd = wr_data;
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic pulse_error();
        rx_error = 1'b1;
        @(posedge clk);
        #1;
        rx_error = 1'b0;
    endtask

    // Sends a full frame using pl[]; pushes the writes a correct parser must make
    task automatic send_frame(input logic [7:0] cmd, input logic [7:0] addr,
                              input logic [7:0] len, input bit use_csum,
                              input logic [7:0] csum_val);
        logic [7:0] c;
        logic [7:0] sent;
        c = cmd ^ addr ^ len;
        for (int i = 0; i < int'(len); i++) c = c ^ pl[i];
        sent = use_csum ? csum_val : c;
        if (cmd == 8'h01 && len != 0 && sent == c) begin
            for (int i = 0; i < int'(len); i++) exp_q.push_back({addr + 8'(i), pl[i]});
        end
        send_byte(8'h55);
        send_byte(cmd);
        send_byte(addr);
        send_byte(len);
        for (int i = 0; i < int'(len); i++) send_byte(pl[i]);
        send_byte(sent);
    endtask

    task automatic wait_result(input int ok0, input int f0, input int budget, input string name);
        bit done = 1'b0;
        for (int n = 0; n < budget && !done; n++) begin
            if (ok_seen != ok0 || ferr_seen != f0) done = 1'b1;
            else idle(1);
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s_wait: no frame_ok/frame_err within %0d cycles", name, budget);
        end
    endtask

    task automatic expect_abort(input int ok0, input int f0, input logic [1:0] code, input string name);
        if (exp_err_cnt < 255) exp_err_cnt++;
        checks++;
        if (ferr_seen - f0 !== 1 || ok_seen != ok0) begin
            errors++;
            $display("FAIL %s_pulse: frame_err=%0d frame_ok=%0d required 1 0", name, ferr_seen - f0, ok_seen - ok0);
        end
        checks++;
        if (err_code !== code || err_cnt !== 8'(exp_err_cnt)) begin
            errors++;
            $display("FAIL %s_status: err_code=%0d err_cnt=%0d required %0d %0d",
                     name, err_code, err_cnt, code, exp_err_cnt);
        end
    endtask

    task automatic expect_ok(input int ok0, input int f0, input int w0, input int nw, input string name);
        checks++;
        if (ok_seen - ok0 !== 1 || ferr_seen != f0) begin
            errors++;
            $display("FAIL %s_pulse: frame_ok=%0d frame_err=%0d required 1 0", name, ok_seen - ok0, ferr_seen - f0);
        end
        checks++;
        if (wr_seen - w0 !== nw || exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_writes: writes=%0d pending=%0d required %0d 0", name, wr_seen - w0, exp_q.size(), nw);
        end
    endtask

    task automatic wait_wr_en(input string name);
        int n = 0;
        while (!wr_en && n < 50) begin
            idle(1);
            n++;
        end
        if (!wr_en) begin
            checks++;
            errors++;
            $display("FAIL %s_wr_en: wr_en=0 required 1 within 50 cycles", name);
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        idle(3);
        checks++;
        if ({wr_en, frame_ok, frame_err, rx_drop, err_code, err_cnt, wr_addr, wr_data} !== '0) begin
            errors++;
            $display("FAIL reset: wr_en=%b ok=%b err=%b drop=%b code=%0d cnt=%0d addr=%h data=%h required all 0",
                     wr_en, frame_ok, frame_err, rx_drop, err_code, err_cnt, wr_addr, wr_data);
        end
        resetn = 1'b1;
        exp_err_cnt = 0;
        idle(2);
    endtask

    task automatic test_good_write();
        int ok0 = ok_seen, f0 = ferr_seen, w0 = wr_seen;
        wr_ready = 1'b1;
        pl[0] = 8'hAA; pl[1] = 8'hBB;
        send_byte(8'h13);  // noise before sync is ignored
        send_frame(8'h01, 8'h10, 8'h02, 1'b0, 8'h00);
        wait_result(ok0, f0, 50, "good_write");
        idle(2);
        expect_ok(ok0, f0, w0, 2, "good_write");
    endtask

    task automatic test_bad_csum();
        int ok0 = ok_seen, f0 = ferr_seen, w0 = wr_seen;
        pl[0] = 8'hAA; pl[1] = 8'hBB;
        send_frame(8'h01, 8'h10, 8'h02, 1'b1, 8'h00);
        wait_result(ok0, f0, 50, "bad_csum");
        idle(2);
        expect_abort(ok0, f0, 2'd1, "bad_csum");
        checks++;
        if (wr_seen != w0) begin
            errors++;
            $display("FAIL bad_csum_nowrite: writes=%0d required 0", wr_seen - w0);
        end
    endtask

    // Releases each pending write after a 5-cycle stall; optional byte/error injected while stalled
    task automatic drain_stalled(input int nw, input bit inject, input string name);
        for (int k = 0; k < nw; k++) begin
            wait_wr_en(name);
            idle(2);
            if (inject && k == 0) begin
                send_byte(8'h55);
                pulse_error();
                idle(1);
            end else begin
                idle(3);
            end
            wr_ready = 1'b1;
            idle(1);
            wr_ready = 1'b0;
        end
    endtask

    task automatic test_wrap_stall();
        int ok0 = ok_seen, f0 = ferr_seen, w0 = wr_seen;
        wr_ready = 1'b0;
        pl[0] = 8'h01; pl[1] = 8'h02;
        send_frame(8'h01, 8'hFF, 8'h02, 1'b0, 8'h00);
        drain_stalled(2, 1'b0, "wrap_stall");
        wait_result(ok0, f0, 20, "wrap_stall");
        idle(2);
        expect_ok(ok0, f0, w0, 2, "wrap_stall");
        wr_ready = 1'b1;
    endtask

    task automatic test_len_cmd_errors();
        int ok0 = ok_seen, f0 = ferr_seen;
        send_byte(8'h55); send_byte(8'h01); send_byte(8'h00); send_byte(8'h11);
        checks++;
        if (frame_err !== 1'b1) begin
            errors++;
            $display("FAIL len_too_big_same_cycle: frame_err=%b required 1", frame_err);
        end
        idle(1);
        expect_abort(ok0, f0, 2'd2, "len_too_big");
        ok0 = ok_seen; f0 = ferr_seen;
        send_byte(8'h55); send_byte(8'h03); send_byte(8'h00); send_byte(8'h00);
        idle(1);
        expect_abort(ok0, f0, 2'd2, "bad_cmd");
    endtask

    task automatic test_timeout();
        int ok0 = ok_seen, f0 = ferr_seen, cyc = 0;
        send_byte(8'h55);
        send_byte(8'h01);
        while (!frame_err && cyc < 1100) begin
            idle(1);
            cyc++;
        end
        checks++;
        if (cyc !== TIMEOUT) begin
            errors++;
            $display("FAIL timeout_latency: cycles=%0d required %0d", cyc, TIMEOUT);
        end
        idle(1);
        expect_abort(ok0, f0, 2'd3, "timeout");
    endtask

    task automatic test_rx_error();
        int ok0 = ok_seen, f0 = ferr_seen;
        send_byte(8'h55); send_byte(8'h01); send_byte(8'h10);
        pulse_error();
        idle(1);
        expect_abort(ok0, f0, 2'd3, "rx_error");
    endtask

    task automatic test_rx_drop();
        int ok0 = ok_seen, f0 = ferr_seen, w0 = wr_seen, d0 = drop_seen;
        wr_ready = 1'b0;
        pl[0] = 8'h5A; pl[1] = 8'hC3; pl[2] = 8'h7E;
        send_frame(8'h01, 8'h80, 8'h03, 1'b0, 8'h00);
        drain_stalled(3, 1'b1, "rx_drop");
        wait_result(ok0, f0, 20, "rx_drop");
        idle(2);
        checks++;
        if (drop_seen - d0 !== 1) begin
            errors++;
            $display("FAIL rx_drop_pulse: drops=%0d required 1", drop_seen - d0);
        end
        expect_ok(ok0, f0, w0, 3, "rx_drop");
        wr_ready = 1'b1;
    endtask

    task automatic test_back_to_back();
        int ok0, f0, w0;
        wr_ready = 1'b1;
        ok0 = ok_seen; f0 = ferr_seen; w0 = wr_seen;
        send_frame(8'h01, 8'h20, 8'h00, 1'b0, 8'h00);
        wait_result(ok0, f0, 20, "len0");
        idle(1);
        expect_ok(ok0, f0, w0, 0, "len0");
        ok0 = ok_seen; f0 = ferr_seen; w0 = wr_seen;
        pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33;
        send_frame(8'h02, 8'h30, 8'h03, 1'b0, 8'h00);
        wait_result(ok0, f0, 20, "ping");
        idle(1);
        expect_ok(ok0, f0, w0, 0, "ping");
        ok0 = ok_seen; f0 = ferr_seen; w0 = wr_seen;
        for (int i = 0; i < MAXLEN; i++) pl[i] = (i % 3 == 0) ? 8'h55 : 8'(i * 17 + 3);
        send_frame(8'h01, 8'hF8, 8'(MAXLEN), 1'b0, 8'h00);
        wait_result(ok0, f0, 60, "maxlen");
        idle(1);
        expect_ok(ok0, f0, w0, MAXLEN, "maxlen");
        ok0 = ok_seen; f0 = ferr_seen;
        send_byte(8'h55); send_byte(8'h01); send_byte(8'h10);
        rx_data = 8'h02; rx_valid = 1'b1; rx_error = 1'b1;
        idle(1);
        rx_valid = 1'b0; rx_error = 1'b0;
        idle(1);
        expect_abort(ok0, f0, 2'd3, "valid_and_error");
    endtask

    task automatic test_reset_commit();
        int ok0, f0, w0;
        wr_ready = 1'b0;
        pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33;
        send_frame(8'h01, 8'h40, 8'h03, 1'b0, 8'h00);
        wait_wr_en("reset_commit");
        idle(2);
        ok0 = ok_seen; w0 = wr_seen;
        resetn = 1'b0;
        idle(1);
        checks++;
        if (wr_en !== 1'b0 || frame_ok !== 1'b0 || err_cnt !== 8'd0) begin
            errors++;
            $display("FAIL reset_commit: wr_en=%b frame_ok=%b err_cnt=%0d required 0 0 0", wr_en, frame_ok, err_cnt);
        end
        resetn = 1'b1;
        exp_q.delete();
        exp_err_cnt = 0;
        wr_ready = 1'b1;
        idle(20);
        checks++;
        if (ok_seen != ok0 || wr_seen != w0) begin
            errors++;
            $display("FAIL reset_commit_quiet: frame_ok=%0d writes=%0d required 0 0", ok_seen - ok0, wr_seen - w0);
        end
        ok0 = ok_seen; f0 = ferr_seen; w0 = wr_seen;
        send_frame(8'h02, 8'h00, 8'h00, 1'b0, 8'h00);
        wait_result(ok0, f0, 20, "after_reset");
        idle(1);
        expect_ok(ok0, f0, w0, 0, "after_reset");
    endtask

    task automatic test_err_saturate();
        int f0 = ferr_seen;
        for (int i = 0; i < 256; i++) begin
            send_byte(8'h55);
            pulse_error();
            if (exp_err_cnt < 255) exp_err_cnt++;
            if (i == 254 || i == 255) begin
                checks++;
                if (err_cnt !== 8'(exp_err_cnt) || err_code !== 2'd3) begin
                    errors++;
                    $display("FAIL err_saturate_%0d: err_cnt=%0d code=%0d required %0d 3", i, err_cnt, err_code, exp_err_cnt);
                end
            end
        end
        idle(1);
        checks++;
        if (ferr_seen - f0 !== 256) begin
            errors++;
            $display("FAIL err_saturate_pulses: frame_err=%0d required 256", ferr_seen - f0);
        end
    endtask

    initial begin
        fork
            monitor();
        join_none
        #1;
        test_reset();
        test_good_write();
        test_bad_csum();
        test_wrap_stall();
        test_len_cmd_errors();
        test_timeout();
        test_rx_error();
        test_rx_drop();
        test_back_to_back();
        test_reset_commit();
        test_err_saturate();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover_writes: pending=%0d required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
